// File: rtl/wash_seq.sv
// wash_seq: washing-machine program sequencer.
//
// Flow: IDLE -> SELECT -> FILL -> WASH -> DRAIN -> SPIN -> BILL -> IDLE.
// All phase timing is derived from an internal tick that fires every
// TICK_DIV clk cycles. The tick counter restarts on every state entry.
//
// Optional feature macro: WASH_SEQ_PAUSE_EN
//   defined   : confirm in FILL/WASH/DRAIN/SPIN toggles a pause flag that
//               freezes the tick counter and remain; st_light[7] shows it.
//   undefined : confirm is ignored in the run phases; st_light[7] stays 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             pulse, IDLE -> SELECT
//   confirm           pulse, accept selection (SELECT) / finish billing (BILL)
//   up, down          pulses, step the program index in SELECT
//   balance           inserted credit, sampled on an accepted confirm
//   wash_time, price  per-program tables, program k at [k*W +: W]
//   fine              overtime fine added every FINE_T ticks in BILL
//   state, mode       current state code and selected program
//   remain            seconds left in WASH/SPIN, 0 elsewhere
//   wt_light          thermometer water-level bar
//   st_light          one-hot state lights (bit 7 = paused)
//   charge, change    amount owed and change due, BILL only
//   reject            1-cycle pulse on insufficient credit
//   buzzer            level, high throughout BILL
// WT_LEVELS must be at least 2.
module wash_seq #(
  parameter int NUM_MODES = 4,
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIME_W    = 8,
  parameter int PRICE_W   = 12,
  parameter int WT_LEVELS = 8,
  parameter int SPIN_T    = 5,
  parameter int FINE_T    = 10,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           confirm,
  input  logic                           up,
  input  logic                           down,
  input  logic [PRICE_W-1:0]             balance,
  input  logic [NUM_MODES*TIME_W-1:0]    wash_time,
  input  logic [NUM_MODES*PRICE_W-1:0]   price,
  input  logic [PRICE_W-1:0]             fine,
  output logic [2:0]                     state,
  output logic [MW-1:0]                  mode,
  output logic [TIME_W-1:0]              remain,
  output logic [WT_LEVELS-1:0]           wt_light,
  output logic [7:0]                     st_light,
  output logic [PRICE_W-1:0]             charge,
  output logic [PRICE_W-1:0]             change,
  output logic                           reject,
  output logic                           buzzer
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FCW = (FINE_T > 1) ? $clog2(FINE_T) : 1;
  localparam logic [TCW-1:0]    TC_LAST   = TCW'(TICK_DIV - 1);
  localparam logic [FCW-1:0]    FC_LAST   = FCW'(FINE_T - 1);
  localparam logic [MW-1:0]     MODE_LAST = MW'(NUM_MODES - 1);
  localparam logic [TIME_W-1:0] SPIN_LD   = TIME_W'(SPIN_T);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_FILL   = 3'd2,
    S_WASH   = 3'd3,
    S_DRAIN  = 3'd4,
    S_SPIN   = 3'd5,
    S_BILL   = 3'd6
  } state_t;

  state_t               st;
  logic [6:0]           st_lo;
  logic [TCW-1:0]       tcnt;
  logic [FCW-1:0]       fcnt;
  logic [PRICE_W-1:0]   bal_q, price_q;
  logic [TIME_W-1:0]    wtime_q;
  logic                 paused;
  logic                 counting, tick, run_done, fine_due;
  logic [PRICE_W-1:0]   sel_price, charge_nxt;
  logic [TIME_W-1:0]    sel_wtime;
  logic [PRICE_W:0]     charge_sum;

  assign state    = st;
  assign st_light = {paused, st_lo};

  assign sel_price = price[int'(mode)*PRICE_W +: PRICE_W];
  assign sel_wtime = wash_time[int'(mode)*TIME_W +: TIME_W];

  assign counting = (st != S_IDLE) && (st != S_SELECT);
  assign tick     = counting && !paused && (tcnt == TC_LAST);

  // WASH/SPIN finish: either loaded with 0, or the tick that takes remain 1->0.
  assign run_done = (remain == '0) || (tick && remain == TIME_W'(1));

  // Overtime fine, saturating at all ones.
  assign fine_due   = tick && (fcnt == FC_LAST);
  assign charge_sum = {1'b0, charge} + {1'b0, fine};
  assign charge_nxt = !fine_due ? charge :
                      charge_sum[PRICE_W] ? '1 : charge_sum[PRICE_W-1:0];

  function automatic logic [PRICE_W-1:0] sub_clamp(input logic [PRICE_W-1:0] a,
                                                   input logic [PRICE_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

`ifdef WASH_SEQ_PAUSE_EN
  logic in_run;
  assign in_run = (st == S_FILL) || (st == S_WASH) || (st == S_DRAIN) || (st == S_SPIN);

  always_ff @(posedge clk) begin
    if (rst)                        paused <= 1'b0;
    else if (st == S_SPIN && run_done) paused <= 1'b0;  // entering BILL
    else if (in_run && confirm)     paused <= ~paused;
  end
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      st_lo    <= 7'd1;
      mode     <= '0;
      remain   <= '0;
      wt_light <= '0;
      charge   <= '0;
      change   <= '0;
      reject   <= 1'b0;
      buzzer   <= 1'b0;
      tcnt     <= '0;
      fcnt     <= '0;
      bal_q    <= '0;
      price_q  <= '0;
      wtime_q  <= '0;
    end else begin
      reject <= 1'b0;
      // Free-running tick counter; every transition below overrides it to 0.
      if (tick)                     tcnt <= '0;
      else if (counting && !paused) tcnt <= tcnt + 1'b1;

      case (st)
        S_IDLE: begin
          if (start) begin
            st    <= S_SELECT;
            st_lo <= 7'd2;
            mode  <= '0;
          end
        end

        S_SELECT: begin
          if (confirm) begin
            if (balance >= sel_price) begin
              st      <= S_FILL;
              st_lo   <= 7'd4;
              bal_q   <= balance;
              price_q <= sel_price;
              wtime_q <= sel_wtime;
              tcnt    <= '0;
            end else begin
              reject <= 1'b1;
            end
          end else if (up && !down) begin
            mode <= (mode == MODE_LAST) ? '0 : mode + 1'b1;
          end else if (down && !up) begin
            mode <= (mode == '0) ? MODE_LAST : mode - 1'b1;
          end
        end

        S_FILL: begin
          if (tick) begin
            wt_light <= {wt_light[WT_LEVELS-2:0], 1'b1};
            if (wt_light[WT_LEVELS-2:0] == '1) begin
              st     <= S_WASH;
              st_lo  <= 7'd8;
              remain <= wtime_q;
              tcnt   <= '0;
            end
          end
        end

        S_WASH: begin
          if (run_done) begin
            st     <= S_DRAIN;
            st_lo  <= 7'd16;
            remain <= '0;
            tcnt   <= '0;
          end else if (tick) begin
            remain <= remain - 1'b1;
          end
        end

        S_DRAIN: begin
          if (tick) begin
            wt_light <= {1'b0, wt_light[WT_LEVELS-1:1]};
            if (wt_light[WT_LEVELS-1:1] == '0) begin
              st     <= S_SPIN;
              st_lo  <= 7'd32;
              remain <= SPIN_LD;
              tcnt   <= '0;
            end
          end
        end

        S_SPIN: begin
          if (run_done) begin
            st     <= S_BILL;
            st_lo  <= 7'd64;
            remain <= '0;
            charge <= price_q;
            change <= sub_clamp(bal_q, price_q);
            buzzer <= 1'b1;
            fcnt   <= '0;
            tcnt   <= '0;
          end else if (tick) begin
            remain <= remain - 1'b1;
          end
        end

        S_BILL: begin
          // confirm takes priority over a fine landing in the same cycle
          if (confirm) begin
            st     <= S_IDLE;
            st_lo  <= 7'd1;
            mode   <= '0;
            charge <= '0;
            change <= '0;
            buzzer <= 1'b0;
            fcnt   <= '0;
            tcnt   <= '0;
          end else if (tick) begin
            fcnt   <= fine_due ? '0 : fcnt + 1'b1;
            charge <= charge_nxt;
            change <= sub_clamp(bal_q, charge_nxt);
          end
        end

        default: begin
          st    <= S_IDLE;
          st_lo <= 7'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wash_seq.sv
// Self-checking bench for wash_seq (default build, pause feature off).
// The expected trace of a run is computed from phase lengths in ticks.
module tb_wash_seq;
  localparam int NM = 4, TD = 4, TW = 8, PW = 12, WL = 8, SP = 2, FT = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst, start, confirm, up, down;
  logic [PW-1:0]     balance, fine;
  logic [NM*TW-1:0]  wash_time;
  logic [NM*PW-1:0]  price;
  logic [2:0]        state;
  logic [1:0]        mode;
  logic [TW-1:0]     remain;
  logic [WL-1:0]     wt_light;
  logic [7:0]        st_light;
  logic [PW-1:0]     charge, change;
  logic              reject, buzzer;

  int total = 0;
  int bad   = 0;
  int mmode = 0;

  always #5 clk = ~clk;

  wash_seq #(
    .NUM_MODES(NM), .TICK_DIV(TD), .TIME_W(TW), .PRICE_W(PW),
    .WT_LEVELS(WL), .SPIN_T(SP), .FINE_T(FT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .confirm(confirm), .up(up), .down(down),
    .balance(balance), .wash_time(wash_time), .price(price), .fine(fine),
    .state(state), .mode(mode), .remain(remain), .wt_light(wt_light),
    .st_light(st_light), .charge(charge), .change(change),
    .reject(reject), .buzzer(buzzer)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".state"}, 32'(state), 0);
    chk({tag, ".st_light"}, 32'(st_light), 1);
    chk({tag, ".mode"}, 32'(mode), 0);
    chk({tag, ".remain"}, 32'(remain), 0);
    chk({tag, ".wt"}, 32'(wt_light), 0);
    chk({tag, ".charge"}, 32'(charge), 0);
    chk({tag, ".change"}, 32'(change), 0);
    chk({tag, ".buzzer"}, 32'(buzzer), 0);
    chk({tag, ".reject"}, 32'(reject), 0);
  endtask

  // one-cycle pulse on up (1) or down (0); inputs change at negedge
  task automatic press(input bit is_up);
    if (is_up) up = 1'b1; else down = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    mmode = is_up ? (mmode + 1) % NM : (mmode + NM - 1) % NM;
  endtask

  task automatic go_mode(input int target);
    while (mmode != target) press(1'b1);
    chk("sel.mode", 32'(mode), 32'(target));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mmode = 0;
    chk("start.state", 32'(state), 1);
    chk("start.mode", 32'(mode), 0);
  endtask

  // Expected outputs c cycles after entering FILL.
  task automatic expect_run(input int c, input int m, input int wt, input int pr,
                            input int bal, input int fn);
    int wl, w_end, d_end, s_end, es, erem, ewt, ech, echg, ebz, k;
    wl    = (wt == 0) ? 1 : TD * wt;
    w_end = TD * WL + wl;
    d_end = w_end + TD * WL;
    s_end = d_end + TD * SP;
    erem = 0; ewt = 0; ech = 0; echg = 0; ebz = 0;
    if (c < TD * WL) begin
      es = 2; ewt = (1 << (c / TD)) - 1;
    end else if (c < w_end) begin
      es = 3; ewt = (1 << WL) - 1; erem = (wt == 0) ? 0 : wt - (c - TD * WL) / TD;
    end else if (c < d_end) begin
      es = 4; ewt = ((1 << WL) - 1) >> ((c - w_end) / TD);
    end else if (c < s_end) begin
      es = 5; erem = SP - (c - d_end) / TD;
    end else begin
      es  = 6; ebz = 1;
      k   = ((c - s_end) / TD) / FT;
      ech = pr + k * fn;
      if (ech > PMAX) ech = PMAX;
      echg = (bal >= ech) ? bal - ech : 0;
    end
    chk("run.state", 32'(state), 32'(es));
    chk("run.st_light", 32'(st_light), 32'(1 << es));
    chk("run.mode", 32'(mode), 32'(m));
    chk("run.remain", 32'(remain), 32'(erem));
    chk("run.wt", 32'(wt_light), 32'(ewt));
    chk("run.charge", 32'(charge), 32'(ech));
    chk("run.change", 32'(change), 32'(echg));
    chk("run.buzzer", 32'(buzzer), 32'(ebz));
    chk("run.reject", 32'(reject), 0);
  endtask

  // DUT must be in SELECT at mode m. Runs a full program and stays bill_cyc
  // cycles in BILL before confirming; abort_at >= 0 pulses rst at that cycle.
  task automatic do_run(input int m, input int wt, input int pr, input int bal,
                        input int fn, input int bill_cyc, input int abort_at);
    int wl, s_end, tot;
    wash_time[m*TW +: TW] = TW'(wt);
    price[m*PW +: PW]     = PW'(pr);
    balance = PW'(bal);
    fine    = PW'(fn);
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    wl    = (wt == 0) ? 1 : TD * wt;
    s_end = 2 * TD * WL + wl + TD * SP;
    tot   = s_end + bill_cyc;
    for (int c = 0; c < tot; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mmode = 0;
        chk_idle("abort");
        return;
      end
      expect_run(c, m, wt, pr, bal, fn);
      // latched inputs must no longer matter
      if (c == 1) begin
        wash_time = {$urandom, $urandom};
        price     = {$urandom, $urandom};
        balance   = PW'($urandom);
      end
      // inputs that are ignored in these states
      up    = 1'($urandom_range(0, 1));
      down  = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if (c < s_end) confirm = ($urandom_range(0, 7) == 0);
      if (c == tot - 1) begin
        up = 1'b0; down = 1'b0; start = 1'b0; confirm = 1'b1;
      end
      @(negedge clk);
      up = 1'b0; down = 1'b0; start = 1'b0; confirm = 1'b0;
    end
    mmode = 0;
    chk_idle("end");
  endtask

  initial begin
    int m, wt, pr, bal, fn, bc;
    rst = 1'b1; start = 1'b0; confirm = 1'b0; up = 1'b0; down = 1'b0;
    balance = '0; fine = '0; wash_time = '0; price = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    // up/confirm in IDLE do nothing
    up = 1'b1; confirm = 1'b1;
    @(negedge clk);
    up = 1'b0; confirm = 1'b0;
    chk_idle("idle_ign");

    // program selection with wrap
    do_start();
    repeat (5) press(1'b1);
    chk("up5.mode", 32'(mode), 1);
    repeat (2) press(1'b0);
    chk("down2.mode", 32'(mode), 3);
    up = 1'b1; down = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    chk("updown.mode", 32'(mode), 3);
    go_mode(1);

    // insufficient credit
    price[1*PW +: PW] = PW'(23);
    balance = PW'(20);
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    chk("rej.pulse", 32'(reject), 1);
    chk("rej.state", 32'(state), 1);
    @(negedge clk);
    chk("rej.clear", 32'(reject), 0);
    chk("rej.state2", 32'(state), 1);

    // accepted: charge 23, change 7
    do_run(1, 2, 23, 30, 5, 4, -1);

    // full run, overtime fine with change clamped to 0
    do_start();
    do_run(0, 3, 100, 130, 28, 26, -1);

    // confirm on the cycle a fine would land
    do_start();
    go_mode(2);
    do_run(2, 1, 50, 60, 7, TD * FT * 3, -1);

    // zero wash time and saturating charge
    do_start();
    go_mode(3);
    do_run(3, 0, 4000, 4095, 50, 30, -1);

    // reset mid-WASH
    do_start();
    go_mode(2);
    do_run(2, 4, 10, 10, 1, 5, TD * WL + 6);

    // randomized programs
    for (int i = 0; i < 4; i++) begin
      m   = $urandom_range(0, NM - 1);
      wt  = $urandom_range(0, 4);
      pr  = $urandom_range(0, 3000);
      bal = $urandom_range(0, 4095);
      fn  = $urandom_range(0, 600);
      bc  = $urandom_range(1, 30);
      do_start();
      go_mode(m);
      if (bal < pr) begin
        price[m*PW +: PW] = PW'(pr);
        balance = PW'(bal);
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        chk("rrej.pulse", 32'(reject), 1);
        chk("rrej.state", 32'(state), 1);
        bal = pr + $urandom_range(0, 4095 - pr);
      end
      do_run(m, wt, pr, bal, fn, bc, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
